// File: rtl/des_sequencer.sv
// des_sequencer: control FSM for one DES block (IP stage, 16 Feistel rounds, FP stage)
// Ports: clk/set (async active-high reset); start/decrypt/busy/done/error to the crypto front-end;
// ip_set/ip_status and fp_set/fp_status to the permutation stages; rnd_start/rnd_done to the round
// engine; round_idx/key_idx/key_shift/key_dir to the key schedule.
// Optional macro DES_SEQ_CYCLE_COUNT_EN adds cycles_last, the busy-cycle count of the last completed block.
module des_sequencer #(
  parameter int NUM_ROUNDS     = 16,
  parameter int TIMEOUT_CYCLES = 255,
  parameter int TW             = 8
) (
  input  logic       clk,
  input  logic       set,
  input  logic       start,
  input  logic       decrypt,
  output logic       busy,
  output logic       done,
  output logic       error,
  output logic       ip_set,
  input  logic       ip_status,
  output logic       rnd_start,
  input  logic       rnd_done,
  output logic [3:0] round_idx,
  output logic [3:0] key_idx,
  output logic [1:0] key_shift,
  output logic       key_dir,
  output logic       fp_set,
  input  logic       fp_status
`ifdef DES_SEQ_CYCLE_COUNT_EN
  ,
  output logic [15:0] cycles_last
`endif
);
  typedef enum logic [2:0] {IDLE, IP_RUN, RND_START, RND_WAIT, FP_RUN, DONE} state_t;
  localparam logic [3:0] LAST = 4'(NUM_ROUNDS - 1);
  state_t state_q, state_d;
  logic [3:0] round_q, round_d;
  logic dec_q, dec_d, err_q, err_d, waiting;
  logic [TW-1:0] wd_q, wd_d;
  always_comb begin
    state_d = state_q;
    round_d = round_q;
    dec_d   = dec_q;
    err_d   = err_q;
    wd_d    = '0;
    waiting = state_q == IP_RUN || state_q == RND_WAIT || state_q == FP_RUN;
    case (state_q)
      IDLE: if (start) begin
        state_d = IP_RUN;
        dec_d   = decrypt;
        err_d   = 1'b0;
        round_d = 4'd0;
      end
      IP_RUN:    if (ip_status) state_d = RND_START;
      RND_START: state_d = RND_WAIT;
      RND_WAIT: if (rnd_done) begin
        state_d = round_q == LAST ? FP_RUN : RND_START;
        round_d = round_q == LAST ? round_q : round_q + 4'd1;
      end
      FP_RUN:    if (fp_status) state_d = DONE;
      DONE:      state_d = IDLE;
      default:   state_d = IDLE;
    endcase
    // the counter survives only while a wait state persists; any transition leaves it cleared
    if (waiting && state_d == state_q) begin
      if (TIMEOUT_CYCLES != 0 && wd_q == TW'(TIMEOUT_CYCLES - 1)) begin
        state_d = IDLE;
        err_d   = 1'b1;
      end else begin
        wd_d = wd_q + TW'(1);
      end
    end
  end
  always_ff @(posedge clk or posedge set) begin
    if (set) begin
      state_q <= IDLE;
      round_q <= 4'd0;
      dec_q   <= 1'b0;
      err_q   <= 1'b0;
      wd_q    <= '0;
    end else begin
      state_q <= state_d;
      round_q <= round_d;
      dec_q   <= dec_d;
      err_q   <= err_d;
      wd_q    <= wd_d;
    end
  end
  assign busy      = state_q != IDLE;
  assign done      = state_q == DONE;
  assign error     = err_q;
  assign ip_set    = state_q == IDLE;
  assign fp_set    = !(state_q == FP_RUN || state_q == DONE);
  assign rnd_start = state_q == RND_START;
  assign round_idx = round_q;
  assign key_idx   = dec_q ? LAST - round_q : round_q;
  assign key_dir   = dec_q;
  // single-bit rotations fall on rounds 0,1,8,15; decrypt round 0 uses the unrotated key
  assign key_shift = state_q == IDLE ? 2'd0 :
                     !(round_q == 4'd0 || round_q == 4'd1 || round_q == 4'd8 || round_q == 4'd15) ? 2'd2 :
                     (dec_q && round_q == 4'd0) ? 2'd0 : 2'd1;
`ifdef DES_SEQ_CYCLE_COUNT_EN
  logic [15:0] cnt_q, cnt_d, cyc_q, cyc_d;
  always_comb begin
    cnt_d = (state_q == IDLE && start) ? 16'd0 : (busy && cnt_q != 16'hFFFF) ? cnt_q + 16'd1 : cnt_q;
    cyc_d = state_q == DONE ? cnt_q : cyc_q;
  end
  always_ff @(posedge clk or posedge set) begin
    if (set) begin
      cnt_q <= 16'd0;
      cyc_q <= 16'd0;
    end else begin
      cnt_q <= cnt_d;
      cyc_q <= cyc_d;
    end
  end
  assign cycles_last = cyc_q;
`endif
endmodule

// File: tb/tb_des_sequencer.sv
// tb_des_sequencer: randomized self-checking bench for des_sequencer against a transaction-level model
module tb_des_sequencer;
  logic clk = 1'b0, set = 1'b1, start = 1'b0, decrypt = 1'b0;
  logic ip_status = 1'b0, rnd_done = 1'b0, fp_status = 1'b0;
  logic busy, done, error, ip_set, rnd_start, fp_set, key_dir;
  logic [3:0] round_idx, key_idx;
  logic [1:0] key_shift;
`ifdef DES_SEQ_CYCLE_COUNT_EN
  logic [15:0] cycles_last;
`endif
  int checks = 0, fails = 0;
  int enc_sh[16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};
  int dec_sh[16] = '{0, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};
  int ip_dly, fp_dly, rd[16];
  bit stray;
  int ip_seen, fp_seen, rcnt, rk, rs_op, n_rs, n_done;

  always #5 clk = ~clk;

  des_sequencer dut (
    .clk(clk), .set(set), .start(start), .decrypt(decrypt),
    .busy(busy), .done(done), .error(error),
    .ip_set(ip_set), .ip_status(ip_status),
    .rnd_start(rnd_start), .rnd_done(rnd_done),
    .round_idx(round_idx), .key_idx(key_idx), .key_shift(key_shift), .key_dir(key_dir),
    .fp_set(fp_set), .fp_status(fp_status)
`ifdef DES_SEQ_CYCLE_COUNT_EN
    , .cycles_last(cycles_last)
`endif
  );

  // one clock: sample outputs just after the edge, then update the responders' registered replies
  task automatic step();
    bit resp;
    @(posedge clk);
    #1;
    if (rnd_start) begin
      rk = rs_op > 15 ? 15 : rs_op;
      rs_op++;
      n_rs++;
      rcnt = 1;
    end else if (rcnt > 0) rcnt++;
    resp = rcnt > 0 && rcnt == 2 + rd[rk];
    if (resp) rcnt = 0;
    rnd_done = resp || (stray && busy && rs_op == 0);
    ip_seen = ip_set ? 0 : ip_seen + 1;
    ip_status = ip_seen >= 2 + ip_dly;
    fp_seen = fp_set ? 0 : fp_seen + 1;
    fp_status = fp_seen >= 2 + fp_dly;
    if (done) n_done++;
  endtask

  task automatic clear_resp();
    ip_dly = 0; fp_dly = 0; stray = 0;
    for (int k = 0; k < 16; k++) rd[k] = 0;
    ip_seen = 0; fp_seen = 0; rcnt = 0; rk = 0; rs_op = 0;
    ip_status = 0; rnd_done = 0; fp_status = 0;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({busy, done, error, ip_set, fp_set, rnd_start, round_idx, key_idx, key_shift, key_dir} !==
        {1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'd0, 4'd0, 2'd0, 1'b0})
      $display("FAIL reset_values got %b", {busy, done, error, ip_set, fp_set, rnd_start, round_idx, key_idx, key_shift, key_dir});
    set = 1'b0;
    step();
  endtask

  task automatic run_op(input bit dec, input string name);
    int exp_lat, e, k, rs0, d0;
    bit got_done;
    logic [10:0] exp_k, got_k;
    exp_lat = 4 + ip_dly + fp_dly;
    for (int r = 0; r < 16; r++) exp_lat += 2 + rd[r];
    rs0 = n_rs; d0 = n_done; rs_op = 0; got_done = 0; e = 0;
    decrypt = dec; start = 1'b1;
    step();
    start = 1'b0; decrypt = !dec;
    checks++;
    if (busy !== 1'b1 || error !== 1'b0) begin
      fails++;
      $display("FAIL %s accept busy=%b error=%b exp busy=1 error=0", name, busy, error);
    end
    while (!got_done && e < exp_lat + 50) begin
      if (busy && rs_op > 0) begin
        k = rs_op - 1;
        exp_k = {4'(k), 4'(dec ? 15 - k : k), 2'(dec ? dec_sh[k] : enc_sh[k]), dec};
        got_k = {round_idx, key_idx, key_shift, key_dir};
        checks++;
        if (got_k !== exp_k) begin
          fails++;
          $display("FAIL %s key_ctl cycle=%0d got %h exp %h", name, e, got_k, exp_k);
        end
      end
      if (busy) begin
        checks++;
        if (ip_set !== 1'b0) begin
          fails++;
          $display("FAIL %s ip_set_hold cycle=%0d got %b exp 0", name, e, ip_set);
        end
      end
      if (done) begin
        got_done = 1;
        checks++;
        if (e != exp_lat) begin
          fails++;
          $display("FAIL %s latency got %0d exp %0d", name, e, exp_lat);
        end
        checks++;
        if (fp_set !== 1'b0) begin
          fails++;
          $display("FAIL %s fp_set_in_done got %b exp 0", name, fp_set);
        end
      end else begin
        step();
        e++;
      end
    end
    checks++;
    if (!got_done) begin
      fails++;
      $display("FAIL %s no_done within %0d cycles", name, exp_lat + 50);
    end
    step();
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      fails++;
      $display("FAIL %s after_done busy=%b done=%b exp 0 0", name, busy, done);
    end
    checks++;
    if (n_rs - rs0 != 16 || n_done - d0 != 1) begin
      fails++;
      $display("FAIL %s counts rnd_start=%0d done=%0d exp 16 1", name, n_rs - rs0, n_done - d0);
    end
`ifdef DES_SEQ_CYCLE_COUNT_EN
    checks++;
    if (cycles_last !== 16'(exp_lat)) begin
      fails++;
      $display("FAIL %s cycles_last got %0d exp %0d", name, cycles_last, exp_lat);
    end
`endif
  endtask

  task automatic test_encrypt();
    clear_resp();
    run_op(1'b0, "encrypt");
  endtask

  task automatic test_decrypt();
    clear_resp();
    run_op(1'b1, "decrypt");
  endtask

  task automatic test_timeout();
    int d0;
    bit found;
    clear_resp();
    rd[3] = 1000000;
    d0 = n_done; found = 0;
    decrypt = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      if (rnd_start && rs_op == 4) found = 1;
      else step();
    end
    checks++;
    if (!found) begin
      fails++;
      $display("FAIL timeout round3_not_reached");
    end
    repeat (254) step();
    checks++;
    if (error !== 1'b0 || busy !== 1'b1) begin
      fails++;
      $display("FAIL timeout early error=%b busy=%b exp 0 1", error, busy);
    end
    repeat (2) step();
    checks++;
    if (error !== 1'b1 || busy !== 1'b0 || n_done != d0) begin
      fails++;
      $display("FAIL timeout abort error=%b busy=%b dones=%0d exp 1 0 0", error, busy, n_done - d0);
    end
    clear_resp();
    run_op(1'b0, "after_timeout");
  endtask

  task automatic test_start_held();
    int lat, acc, rs0, d0;
    clear_resp();
    stray = 1;
    lat = 36; acc = 0;
    for (int t = 0; t < 40; t += lat + 2) acc++;
    rs0 = n_rs; d0 = n_done;
    decrypt = 1'b0; start = 1'b1;
    step();
    for (int e = 0; e < 120; e++) begin
      if (e == 39) start = 1'b0;
      step();
    end
    checks++;
    if (n_done - d0 != acc || n_rs - rs0 != 16 * acc) begin
      fails++;
      $display("FAIL start_held done=%0d rnd_start=%0d exp %0d %0d", n_done - d0, n_rs - rs0, acc, 16 * acc);
    end
    checks++;
    if (busy !== 1'b0) begin
      fails++;
      $display("FAIL start_held idle busy=%b exp 0", busy);
    end
  endtask

  task automatic test_reset_mid();
    int d0;
    bit found;
    clear_resp();
    d0 = n_done; found = 0;
    decrypt = 1'b1; start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      if (rnd_start && rs_op == 8) found = 1;
      else step();
    end
    checks++;
    if (!found) begin
      fails++;
      $display("FAIL reset_mid round7_not_reached");
    end
    #2 set = 1'b1;
    #1;
    checks++;
    if ({busy, done, error, ip_set, fp_set, rnd_start, round_idx, key_idx, key_shift, key_dir} !==
        {1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'd0, 4'd0, 2'd0, 1'b0}) begin
      fails++;
      $display("FAIL reset_mid async got %b", {busy, done, error, ip_set, fp_set, rnd_start, round_idx, key_idx, key_shift, key_dir});
    end
    repeat (2) step();
    set = 1'b0;
    repeat (3) step();
    checks++;
    if (n_done != d0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL reset_mid after dones=%0d busy=%b exp 0 0", n_done - d0, busy);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 4; n++) begin
      clear_resp();
      ip_dly = $urandom_range(0, 3);
      fp_dly = $urandom_range(0, 3);
      for (int k = 0; k < 16; k++) rd[k] = $urandom_range(0, 4);
      run_op(1'($urandom_range(0, 1)), "random");
    end
  endtask

`ifdef DES_SEQ_CYCLE_COUNT_EN
  task automatic test_cycle_count();
    clear_resp();
    for (int k = 0; k < 16; k++) rd[k] = 3;
    run_op(1'b0, "cycle_count");
    checks++;
    if (cycles_last !== 16'd84) begin
      fails++;
      $display("FAIL cycle_count got %0d exp 84", cycles_last);
    end
    clear_resp();
    rd[3] = 1000000;
    decrypt = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    repeat (400) step();
    checks++;
    if (error !== 1'b1 || cycles_last !== 16'd84) begin
      fails++;
      $display("FAIL cycle_count_abort error=%b cycles_last=%0d exp 1 84", error, cycles_last);
    end
  endtask
`endif

  initial begin
    clear_resp();
    n_rs = 0; n_done = 0;
    test_reset();
    test_encrypt();
    test_decrypt();
    test_timeout();
    test_start_held();
    test_reset_mid();
    test_random();
`ifdef DES_SEQ_CYCLE_COUNT_EN
    test_cycle_count();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
